// File: rtl/apb_ucpd_tx_fsm_if.sv
// Signal bundle between the UCPD register block and the transmit sequencer.
// The master modport drives commands; the slave modport is the sequencer itself.
interface apb_ucpd_tx_fsm_if #(
  parameter int PAYSZ_W = 10
);
  logic               ucpd_en;
  logic               bit_clk_red;
  logic               transmit_en;
  logic               tx_hrst;
  logic [1:0]         tx_mode;
  logic [PAYSZ_W-1:0] tx_paysz;
  logic               rx_busy;

  logic pre_en;
  logic sop_en;
  logic data_en;
  logic crc_en;
  logic eop_en;
  logic bmc_en;
  logic bist_en;
  logic tx_sop_cmplt;
  logic tx_data_cmplt;
  logic tx_crc_cmplt;
  logic tx_eop_cmplt;
  logic tx_wait_cmplt;
  logic txfifo_ld_en;
  logic txdr_req;
  logic tx_msg_disc;
  logic tx_hrst_disc;

  modport master (
    output ucpd_en, bit_clk_red, transmit_en, tx_hrst, tx_mode, tx_paysz, rx_busy,
    input  pre_en, sop_en, data_en, crc_en, eop_en, bmc_en, bist_en,
    input  tx_sop_cmplt, tx_data_cmplt, tx_crc_cmplt, tx_eop_cmplt, tx_wait_cmplt,
    input  txfifo_ld_en, txdr_req, tx_msg_disc, tx_hrst_disc
  );

  modport slave (
    input  ucpd_en, bit_clk_red, transmit_en, tx_hrst, tx_mode, tx_paysz, rx_busy,
    output pre_en, sop_en, data_en, crc_en, eop_en, bmc_en, bist_en,
    output tx_sop_cmplt, tx_data_cmplt, tx_crc_cmplt, tx_eop_cmplt, tx_wait_cmplt,
    output txfifo_ld_en, txdr_req, tx_msg_disc, tx_hrst_disc
  );
endinterface

// File: rtl/apb_ucpd_tx_fsm.sv
// UCPD transmit sequencer: steps PRE/SOP/DATA/CRC/EOP/WAIT on bit_clk_red pulses,
// handles hard/cable reset, BIST carrier and discard on receive activity.
module apb_ucpd_tx_fsm #(
  parameter int PRE_BITS = 128,
  parameter int IFG_BITS = 25,
  parameter int PAYSZ_W  = 10
) (
  input logic              ic_clk,
  input logic              ic_rst_n,
  apb_ucpd_tx_fsm_if.slave tx_if
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_SOP, S_DATA, S_CRC, S_EOP, S_WAIT, S_BIST
  } state_e;

  localparam logic [7:0] PRE_LAST  = 8'(PRE_BITS - 1);
  localparam logic [7:0] SOP_LAST  = 8'd19;
  localparam logic [7:0] BYTE_LAST = 8'd9;
  localparam logic [7:0] CRC_LAST  = 8'd39;
  localparam logic [7:0] EOP_LAST  = 8'd4;
  localparam logic [7:0] IFG_LAST  = 8'(IFG_BITS - 1);

  state_e             state_q, state_d;
  logic [7:0]         bit_cnt_q, bit_cnt_d;
  logic [PAYSZ_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [PAYSZ_W-1:0] paysz_q, paysz_d;
  logic               cable_q, cable_d;
  logic               hrst_flag_q, hrst_flag_d;
  logic               hrst_pend_q, hrst_pend_d;
  logic               txdr_req_q, txdr_req_d;
  logic               te_q, hrst_q;

  logic [7:0] seg_last;
  logic       seg_end, te_rise, hrst_rise, hrst_req, abort, no_payload;

  logic pre_en, sop_en, data_en, crc_en, eop_en, bmc_en, bist_en;
  logic sop_cmplt, data_cmplt, crc_cmplt, eop_cmplt, wait_cmplt;
  logic ld_en, req, msg_disc, hrst_disc;

  always_comb begin
    seg_last = '1;
    unique case (state_q)
      S_PRE:   seg_last = PRE_LAST;
      S_SOP:   seg_last = SOP_LAST;
      S_DATA:  seg_last = BYTE_LAST;
      S_CRC:   seg_last = CRC_LAST;
      S_EOP:   seg_last = EOP_LAST;
      S_WAIT:  seg_last = IFG_LAST;
      default: seg_last = '1;
    endcase
  end

  assign seg_end    = tx_if.bit_clk_red && (bit_cnt_q == seg_last) &&
                      (state_q != S_IDLE) && (state_q != S_BIST);
  assign te_rise    = tx_if.transmit_en && !te_q;
  assign hrst_rise  = tx_if.tx_hrst && !hrst_q;
  assign hrst_req   = hrst_rise || hrst_pend_q;
  assign abort      = hrst_rise && ((state_q == S_SOP) || (state_q == S_DATA) || (state_q == S_CRC));
  assign no_payload = hrst_flag_q || cable_q;

  always_ff @(posedge ic_clk or negedge ic_rst_n) begin
    if (!ic_rst_n) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      paysz_q     <= '0;
      cable_q     <= 1'b0;
      hrst_flag_q <= 1'b0;
      hrst_pend_q <= 1'b0;
      txdr_req_q  <= 1'b0;
      te_q        <= 1'b0;
      hrst_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      paysz_q     <= paysz_d;
      cable_q     <= cable_d;
      hrst_flag_q <= hrst_flag_d;
      hrst_pend_q <= hrst_pend_d;
      txdr_req_q  <= txdr_req_d;
      te_q        <= tx_if.transmit_en;
      hrst_q      <= tx_if.tx_hrst;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = tx_if.bit_clk_red ? bit_cnt_q + 8'd1 : bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    paysz_d     = paysz_q;
    cable_d     = cable_q;
    hrst_flag_d = hrst_flag_q;
    hrst_pend_d = hrst_pend_q;
    if (!tx_if.ucpd_en) begin
      state_d     = S_IDLE;
      byte_cnt_d  = '0;
      cable_d     = 1'b0;
      hrst_flag_d = 1'b0;
      hrst_pend_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          bit_cnt_d = '0;
          // A hard reset (new or latched during a frame) outranks a transmit request
          if (hrst_req) begin
            hrst_pend_d = 1'b0;
            if (!tx_if.rx_busy) begin
              hrst_flag_d = 1'b1;
              state_d     = S_PRE;
            end
          end else if (te_rise && !tx_if.rx_busy) begin
            paysz_d = tx_if.tx_paysz;
            cable_d = (tx_if.tx_mode == 2'b01);
            state_d = (tx_if.tx_mode == 2'b10) ? S_BIST : S_PRE;
          end
        end
        S_PRE: begin
          if (hrst_rise) hrst_pend_d = 1'b1;
          if (seg_end) state_d = S_SOP;
        end
        S_SOP: begin
          if (abort) begin
            hrst_flag_d = 1'b1;
            state_d     = S_EOP;
          end else if (seg_end) begin
            if (no_payload) begin
              hrst_flag_d = 1'b0;
              state_d     = S_WAIT;
            end else if (paysz_q == '0) begin
              state_d = S_CRC;
            end else begin
              byte_cnt_d = paysz_q - 1'b1;
              state_d    = S_DATA;
            end
          end
        end
        S_DATA: begin
          if (abort) begin
            hrst_flag_d = 1'b1;
            state_d     = S_EOP;
          end else if (seg_end) begin
            bit_cnt_d = '0;
            if (byte_cnt_q == '0) state_d = S_CRC;
            else byte_cnt_d = byte_cnt_q - 1'b1;
          end
        end
        S_CRC: begin
          if (abort) begin
            hrst_flag_d = 1'b1;
            state_d     = S_EOP;
          end else if (seg_end) begin
            state_d = S_EOP;
          end
        end
        S_EOP: begin
          if (hrst_rise) hrst_pend_d = 1'b1;
          if (seg_end) state_d = hrst_flag_q ? S_PRE : S_WAIT;
        end
        S_WAIT: begin
          if (hrst_rise) hrst_pend_d = 1'b1;
          if (seg_end) state_d = S_IDLE;
        end
        S_BIST: begin
          bit_cnt_d = '0;
          if (hrst_rise) hrst_pend_d = 1'b1;
          if (!tx_if.transmit_en) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
    if (!tx_if.ucpd_en || (state_d != state_q)) bit_cnt_d = '0;
    txdr_req_d = ld_en && (byte_cnt_d != '0);
  end

  always_comb begin
    pre_en     = (state_q == S_PRE);
    sop_en     = (state_q == S_SOP);
    data_en    = (state_q == S_DATA);
    crc_en     = (state_q == S_CRC);
    eop_en     = (state_q == S_EOP);
    bist_en    = (state_q == S_BIST);
    bmc_en     = (state_q != S_IDLE);
    sop_cmplt  = 1'b0;
    data_cmplt = 1'b0;
    crc_cmplt  = 1'b0;
    eop_cmplt  = 1'b0;
    wait_cmplt = 1'b0;
    ld_en      = 1'b0;
    req        = 1'b0;
    msg_disc   = 1'b0;
    hrst_disc  = 1'b0;
    if (tx_if.ucpd_en) begin
      req = txdr_req_q && (state_q == S_DATA);
      unique case (state_q)
        S_IDLE: begin
          if (hrst_req) hrst_disc = tx_if.rx_busy;
          else if (te_rise) msg_disc = tx_if.rx_busy;
        end
        S_SOP: begin
          if (seg_end && !abort) begin
            sop_cmplt = 1'b1;
            if (!no_payload) begin
              data_cmplt = (paysz_q == '0);
              ld_en      = (paysz_q != '0);
            end
          end
        end
        S_DATA: begin
          if (seg_end && !abort) begin
            data_cmplt = (byte_cnt_q == '0);
            ld_en      = (byte_cnt_q != '0);
          end
        end
        S_CRC:   crc_cmplt  = seg_end && !abort;
        S_EOP:   eop_cmplt  = seg_end;
        S_WAIT:  wait_cmplt = seg_end;
        default: ;
      endcase
    end
  end

  assign tx_if.pre_en        = pre_en;
  assign tx_if.sop_en        = sop_en;
  assign tx_if.data_en       = data_en;
  assign tx_if.crc_en        = crc_en;
  assign tx_if.eop_en        = eop_en;
  assign tx_if.bmc_en        = bmc_en;
  assign tx_if.bist_en       = bist_en;
  assign tx_if.tx_sop_cmplt  = sop_cmplt;
  assign tx_if.tx_data_cmplt = data_cmplt;
  assign tx_if.tx_crc_cmplt  = crc_cmplt;
  assign tx_if.tx_eop_cmplt  = eop_cmplt;
  assign tx_if.tx_wait_cmplt = wait_cmplt;
  assign tx_if.txfifo_ld_en  = ld_en;
  assign tx_if.txdr_req      = req;
  assign tx_if.tx_msg_disc   = msg_disc;
  assign tx_if.tx_hrst_disc  = hrst_disc;

endmodule

// File: tb/tb_apb_ucpd_tx_fsm.sv
// Scoreboard bench for apb_ucpd_tx_fsm: expected events (output vector + bit count)
// are queued by the stimulus and popped by a monitor whenever a pulse or level change appears.
module tb_apb_ucpd_tx_fsm;
  localparam int PAYSZ_W = 10;

  // pulse bits [8:0], level bits [15:9]
  localparam logic [15:0] P_SOP  = 16'h0001;
  localparam logic [15:0] P_DAT  = 16'h0002;
  localparam logic [15:0] P_CRC  = 16'h0004;
  localparam logic [15:0] P_EOP  = 16'h0008;
  localparam logic [15:0] P_WAIT = 16'h0010;
  localparam logic [15:0] P_LD   = 16'h0020;
  localparam logic [15:0] P_REQ  = 16'h0040;
  localparam logic [15:0] P_MD   = 16'h0080;
  localparam logic [15:0] P_HD   = 16'h0100;
  localparam logic [15:0] L_IDLE = 16'h0000;
  localparam logic [15:0] L_PRE  = 16'h4200;
  localparam logic [15:0] L_SOP  = 16'h4400;
  localparam logic [15:0] L_DATA = 16'h4800;
  localparam logic [15:0] L_CRC  = 16'h5000;
  localparam logic [15:0] L_EOP  = 16'h6000;
  localparam logic [15:0] L_WAIT = 16'h4000;
  localparam logic [15:0] L_BIST = 16'hC000;

  typedef struct {
    logic [15:0] v;
    int unsigned b;
  } ev_t;

  logic ic_clk = 1'b0;
  logic ic_rst_n = 1'b0;
  ev_t exp_q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned nbits = 0;
  int unsigned sent = 0;
  logic [15:0] prev_v = '0;

  apb_ucpd_tx_fsm_if #(.PAYSZ_W(PAYSZ_W)) tx_if ();

  apb_ucpd_tx_fsm #(
    .PRE_BITS(128),
    .IFG_BITS(25),
    .PAYSZ_W (PAYSZ_W)
  ) dut (
    .ic_clk  (ic_clk),
    .ic_rst_n(ic_rst_n),
    .tx_if   (tx_if.slave)
  );

  always #5 ic_clk = ~ic_clk;

  function automatic logic [15:0] snap();
    return {tx_if.bist_en, tx_if.bmc_en, tx_if.eop_en, tx_if.crc_en, tx_if.data_en,
            tx_if.sop_en, tx_if.pre_en, tx_if.tx_hrst_disc, tx_if.tx_msg_disc,
            tx_if.txdr_req, tx_if.txfifo_ld_en, tx_if.tx_wait_cmplt, tx_if.tx_eop_cmplt,
            tx_if.tx_crc_cmplt, tx_if.tx_data_cmplt, tx_if.tx_sop_cmplt};
  endfunction

  always @(negedge ic_clk) begin
    logic [15:0] cur;
    ev_t e;
    if (tx_if.bit_clk_red) nbits++;
    cur = snap();
    if (ic_rst_n && ((cur[8:0] != '0) || (cur[15:9] != prev_v[15:9]))) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got %h at bit %0d, required no event", cur, nbits);
      end else begin
        e = exp_q.pop_front();
        if ((e.v !== cur) || (e.b != nbits)) begin
          errors++;
          $display("FAIL event: got %h at bit %0d, required %h at bit %0d", cur, nbits, e.v, e.b);
        end
      end
    end
    prev_v = cur;
  end

  task automatic ex(input logic [15:0] v, input int unsigned b);
    ev_t e;
    e.v = v;
    e.b = b;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge ic_clk);
    #1;
  endtask

  task automatic run_bits(input int n);
    for (int i = 0; i < n; i++) begin
      tx_if.bit_clk_red = 1'b1;
      cyc(1);
      tx_if.bit_clk_red = 1'b0;
      cyc(3);
      sent++;
    end
  endtask

  // PRE, SOP, then straight to WAIT: hard reset or cable reset ordered set
  task automatic ex_reset_seq(input int unsigned b);
    ex(L_PRE, b);
    ex(L_SOP, b + 128);
    ex(P_SOP | L_SOP, b + 148);
    ex(L_WAIT, b + 148);
    ex(P_WAIT | L_WAIT, b + 173);
    ex(L_IDLE, b + 173);
  endtask

  initial begin
    int unsigned b;
    tx_if.ucpd_en     = 1'b1;
    tx_if.bit_clk_red = 1'b0;
    tx_if.transmit_en = 1'b0;
    tx_if.tx_hrst     = 1'b0;
    tx_if.tx_mode     = 2'b00;
    tx_if.tx_paysz    = '0;
    tx_if.rx_busy     = 1'b0;
    cyc(3);
    checks++;
    if (snap() !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0000", snap());
    end
    ic_rst_n = 1'b1;
    cyc(2);

    // Normal frame, 2 bytes; mode/paysz changes after start must be ignored
    b = sent;
    ex(L_PRE, b);           ex(L_SOP, b + 128);
    ex(P_SOP | P_LD | L_SOP, b + 148);
    ex(P_REQ | L_DATA, b + 148);
    ex(P_LD | L_DATA, b + 158);
    ex(P_DAT | L_DATA, b + 168); ex(L_CRC, b + 168);
    ex(P_CRC | L_CRC, b + 208);  ex(L_EOP, b + 208);
    ex(P_EOP | L_EOP, b + 213);  ex(L_WAIT, b + 213);
    ex(P_WAIT | L_WAIT, b + 238); ex(L_IDLE, b + 238);
    tx_if.tx_paysz = 10'd2;
    tx_if.transmit_en = 1'b1;
    cyc(2);
    tx_if.transmit_en = 1'b0;
    tx_if.tx_paysz = 10'd0;
    tx_if.tx_mode = 2'b01;
    run_bits(238);
    tx_if.tx_mode = 2'b00;
    cyc(4);

    // Zero payload; hard reset raised during PRE is serviced after the frame
    b = sent;
    ex(L_PRE, b);           ex(L_SOP, b + 128);
    ex(P_SOP | P_DAT | L_SOP, b + 148); ex(L_CRC, b + 148);
    ex(P_CRC | L_CRC, b + 188);  ex(L_EOP, b + 188);
    ex(P_EOP | L_EOP, b + 193);  ex(L_WAIT, b + 193);
    ex(P_WAIT | L_WAIT, b + 218); ex(L_IDLE, b + 218);
    ex_reset_seq(b + 218);
    tx_if.transmit_en = 1'b1;
    cyc(2);
    tx_if.transmit_en = 1'b0;
    run_bits(10);
    tx_if.tx_hrst = 1'b1;
    cyc(1);
    tx_if.tx_hrst = 1'b0;
    run_bits(381);
    cyc(4);

    // Hard reset from IDLE
    b = sent;
    ex_reset_seq(b);
    tx_if.tx_hrst = 1'b1;
    cyc(2);
    tx_if.tx_hrst = 1'b0;
    run_bits(173);
    cyc(4);

    // Hard reset at bit 7 of the first data byte
    b = sent;
    ex(L_PRE, b);           ex(L_SOP, b + 128);
    ex(P_SOP | P_LD | L_SOP, b + 148);
    ex(P_REQ | L_DATA, b + 148);
    ex(L_EOP, b + 155);
    ex(P_EOP | L_EOP, b + 160);
    ex_reset_seq(b + 160);
    tx_if.tx_paysz = 10'd2;
    tx_if.transmit_en = 1'b1;
    cyc(2);
    tx_if.transmit_en = 1'b0;
    run_bits(155);
    tx_if.tx_hrst = 1'b1;
    cyc(2);
    tx_if.tx_hrst = 1'b0;
    run_bits(178);
    cyc(4);

    // Cable reset via tx_mode 01
    b = sent;
    ex_reset_seq(b);
    tx_if.tx_mode = 2'b01;
    tx_if.transmit_en = 1'b1;
    cyc(2);
    tx_if.transmit_en = 1'b0;
    tx_if.tx_mode = 2'b00;
    run_bits(173);
    cyc(4);

    // Discards while the receiver is busy
    b = sent;
    ex(P_MD | L_IDLE, b);
    ex(P_HD | L_IDLE, b);
    tx_if.rx_busy = 1'b1;
    tx_if.transmit_en = 1'b1;
    cyc(2);
    tx_if.transmit_en = 1'b0;
    tx_if.tx_hrst = 1'b1;
    cyc(2);
    tx_if.tx_hrst = 1'b0;
    tx_if.rx_busy = 1'b0;
    run_bits(5);
    cyc(2);

    // transmit_en and tx_hrst rising together: hard reset wins
    b = sent;
    ex_reset_seq(b);
    tx_if.transmit_en = 1'b1;
    tx_if.tx_hrst = 1'b1;
    cyc(2);
    tx_if.transmit_en = 1'b0;
    tx_if.tx_hrst = 1'b0;
    run_bits(173);
    cyc(4);

    // BIST carrier for 1000 bits
    b = sent;
    ex(L_BIST, b);
    ex(L_IDLE, b + 1000);
    tx_if.tx_mode = 2'b10;
    tx_if.transmit_en = 1'b1;
    cyc(2);
    run_bits(1000);
    tx_if.transmit_en = 1'b0;
    tx_if.tx_mode = 2'b00;
    cyc(4);

    // ucpd_en dropped mid-preamble
    b = sent;
    ex(L_PRE, b);
    ex(L_IDLE, b + 50);
    tx_if.tx_paysz = 10'd2;
    tx_if.transmit_en = 1'b1;
    cyc(2);
    tx_if.transmit_en = 1'b0;
    run_bits(50);
    tx_if.ucpd_en = 1'b0;
    cyc(2);
    tx_if.ucpd_en = 1'b1;
    run_bits(5);
    cyc(10);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got %0d outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
